// File: rtl/rv_pkg.sv
// Shared types and constants for the integer register-file write side.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/ld_return_fifo.sv
// Synchronous FIFO buffering load returns until they win the write port.
module ld_return_fifo
  import rv_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wb_req_t                   din,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(LD_DEPTH):0] count,
  output wb_req_t                   head
);
  localparam int AW = $clog2(LD_DEPTH);

  // Extra pointer MSB distinguishes full from empty when the indices match.
  logic [AW:0] wptr, rptr;
  wb_req_t     mem [LD_DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU results and buffered load returns onto the single register-file
// write port, and tracks pending loads so decode can stall on their operands.
module rf_writeback_arbiter #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int LD_DEPTH = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [rv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]               alu_wd,
  output logic                          alu_stall,
  input  logic                          ld_issue,
  input  logic [rv_pkg::REG_ADDR_W-1:0] ld_issue_rd,
  input  logic                          ld_valid,
  input  logic [rv_pkg::REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]               ld_data,
  output logic                          ld_ready,
  input  logic [rv_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [rv_pkg::REG_ADDR_W-1:0] rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic [rv_pkg::REG_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]               wd,
  output logic                          wen
);
  import rv_pkg::*;

  localparam int CW     = $clog2(LD_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int NREG   = 2 ** REG_ADDR_W;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(LD_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              fifo_full, fifo_empty, push, grant_ld, grant_alu;
  logic [CW-1:0]     fifo_count;
  wb_req_t           fifo_in, head;
  logic [WAIT_W-1:0] wait_q;
  logic [NREG-1:0]   busy_q, busy_d;

  assign fifo_in  = '{rd: ld_rd, data: ld_data};
  // Readiness comes from the registered count only, so a pop never frees a
  // slot for a push in the same cycle.
  assign ld_ready = (fifo_count < DEPTH_C);
  assign push     = ld_valid && ld_ready;

  ld_return_fifo #(.LD_DEPTH(LD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_in),
    .pop   (grant_ld),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  // Loads yield to the ALU until the head has been passed over MAX_WAIT times.
  assign grant_ld  = !fifo_empty && (!alu_valid || wait_q == WAIT_MAX);
  assign grant_alu = !grant_ld && alu_valid;
  assign alu_stall = alu_valid && grant_ld;

  always_ff @(posedge clk) begin
    if (rst)                                 wait_q <= '0;
    else if (fifo_empty || grant_ld)         wait_q <= '0;
    else if (grant_alu && wait_q != WAIT_MAX) wait_q <= wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a3  <= '0;
      wd  <= '0;
      wen <= 1'b0;
    end else if (grant_ld) begin
      a3  <= head.rd;
      wd  <= head.data;
      wen <= (head.rd != '0);
    end else if (grant_alu) begin
      a3  <= alu_rd;
      wd  <= alu_wd;
      wen <= (alu_rd != '0);
    end else begin
      wen <= 1'b0;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (grant_ld && head.rd != '0)        busy_d[head.rd]     = 1'b0;
    if (ld_issue && ld_issue_rd != '0)    busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

  ld_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(ld_valid && fifo_full));
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scenario tasks drive the arbiter; a write-port monitor checks every write
// against a queue of expected writes filled as stimulus is applied.
module tb_rf_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_issue, ld_valid;
  logic [4:0]  alu_rd, ld_issue_rd, ld_rd, rs1, rs2;
  logic [31:0] alu_wd, ld_data;
  logic        alu_stall, ld_ready, rs1_busy, rs2_busy, wen;
  logic [4:0]  a3;
  logic [31:0] wd;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.XLEN(32), .LD_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .a3(a3), .wd(wd), .wen(wen)
  );

  // Write-port monitor: every enabled write must match the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (wen === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: a3=%0d wd=%h, expected no write", a3, wd);
      end else begin
        e = q.pop_front();
        if (a3 !== e.rd || wd !== e.data) begin
          errors++;
          $display("FAIL wb_data: a3=%0d wd=%h, expected a3=%0d wd=%h", a3, wd, e.rd, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_wd = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rs1 = 5; rs2 = 6;
    rst = 1; cyc(); cyc(); rst = 0;
    #1;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", wen); end
    checks++; if (a3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d want 0", a3); end
    checks++; if (wd !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h want 0", wd); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b want 1", ld_ready); end
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_alu_stall: got %b want 0", alu_stall); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rs1_busy); end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEADBEEF;
    q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    #1;
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", alu_stall); end
    cyc(); idle_inputs(); #1;
    checks++; if (wen !== 1'b1 || a3 !== 5'd5 || wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write: wen=%b a3=%0d wd=%h want 1/5/deadbeef", wen, a3, wd);
    end
    cyc();
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL alu_wen_drop: got %b want 0", wen); end
  endtask

  task automatic test_load();
    ld_issue = 1; ld_issue_rd = 7; rs1 = 7; #1;
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL load_busy_pre: got %b want 0", rs1_busy); end
    cyc(); ld_issue = 0; #1;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL load_busy_set: got %b want 1", rs1_busy); end
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    q.push_back('{rd: 5'd7, data: 32'h1234});
    cyc(); ld_valid = 0; #1;
    checks++; if (wen !== 1'b0 || rs1_busy !== 1'b1) begin
      errors++; $display("FAIL load_lat1: wen=%b busy=%b want 0/1", wen, rs1_busy);
    end
    cyc(); #1;
    checks++; if (wen !== 1'b1 || a3 !== 5'd7 || wd !== 32'h1234) begin
      errors++; $display("FAIL load_write: wen=%b a3=%0d wd=%h want 1/7/1234", wen, a3, wd);
    end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL load_busy_clr: got %b want 0", rs1_busy); end
    cyc();
    checks++; if (wen !== 1'b0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL load_after: wen=%b busy=%b want 0/0", wen, rs1_busy);
    end
  endtask

  // ALU held busy every cycle; each load head is forced through after 4 ALU wins.
  task automatic test_starvation();
    int ai = 0;
    int li = 0;
    bit exp_stall;
    for (int c = 0; c < 12; c++) begin
      alu_valid = 1; alu_rd = 5'(10 + ai); alu_wd = 32'hA000_0000 + ai;
      ld_valid = (c < 2); ld_rd = 5'(20 + c); ld_data = 32'hB000_0000 + c;
      #1;
      exp_stall = (c == 5 || c == 10);
      checks++; if (alu_stall !== exp_stall) begin
        errors++; $display("FAIL starve_stall c=%0d: got %b want %b", c, alu_stall, exp_stall);
      end
      if (c == 2) begin
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL starve_full_ready: got %b want 0", ld_ready); end
      end
      if (c == 6) begin
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL starve_ready_back: got %b want 1", ld_ready); end
      end
      if (exp_stall) begin
        q.push_back('{rd: 5'(20 + li), data: 32'hB000_0000 + li});
        li++;
      end else begin
        q.push_back('{rd: 5'(10 + ai), data: 32'hA000_0000 + ai});
        ai++;
      end
      cyc();
    end
    idle_inputs(); cyc(); cyc();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL starve_drain: %0d writes missing, want 0", q.size()); end
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_wd = 32'hFFFF_FFFF;
    ld_valid = 1; ld_rd = 0; ld_data = 32'h5555_5555;
    ld_issue = 1; ld_issue_rd = 0; rs1 = 0;
    cyc(); idle_inputs(); #1;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL x0_alu_wen: got %b want 0", wen); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", rs1_busy); end
    cyc();
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL x0_ld_wen: got %b want 0", wen); end
    alu_valid = 1; alu_rd = 3; alu_wd = 32'h33;
    q.push_back('{rd: 5'd3, data: 32'h33});
    #1;
    checks++; if (alu_stall !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL x0_drained: stall=%b ready=%b want 0/1", alu_stall, ld_ready);
    end
    cyc(); idle_inputs(); cyc();
  endtask

  task automatic test_set_wins();
    ld_issue = 1; ld_issue_rd = 9;
    cyc(); ld_issue = 0;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    q.push_back('{rd: 5'd9, data: 32'h99});
    cyc(); ld_valid = 0;
    ld_issue = 1; ld_issue_rd = 9; rs1 = 9; #1;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL setwin_pre: got %b want 1", rs1_busy); end
    cyc(); ld_issue = 0; rs2 = 9; #1;
    checks++; if (wen !== 1'b1 || a3 !== 5'd9) begin
      errors++; $display("FAIL setwin_write: wen=%b a3=%0d want 1/9", wen, a3);
    end
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      errors++; $display("FAIL setwin_busy: rs1=%b rs2=%b want 1/1", rs1_busy, rs2_busy);
    end
    cyc();
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL setwin_hold: got %b want 1", rs1_busy); end
  endtask

  task automatic test_reset_mid();
    ld_issue = 1; ld_issue_rd = 12;
    alu_valid = 1; alu_rd = 1; alu_wd = 32'h11;
    ld_valid = 1; ld_rd = 12; ld_data = 32'hC0;
    q.push_back('{rd: 5'd1, data: 32'h11});
    cyc();
    ld_issue_rd = 13; alu_rd = 2; alu_wd = 32'h22; ld_rd = 13; ld_data = 32'hC1;
    q.push_back('{rd: 5'd2, data: 32'h22});
    cyc();
    idle_inputs(); rst = 1;
    cyc(); rst = 0; rs1 = 12; rs2 = 13; #1;
    checks++; if (wen !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_port: wen=%b ready=%b want 0/1", wen, ld_ready);
    end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_busy: rs1=%b rs2=%b want 0/0", rs1_busy, rs2_busy);
    end
    alu_valid = 1; alu_rd = 4; alu_wd = 32'h44;
    q.push_back('{rd: 5'd4, data: 32'h44});
    #1;
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", alu_stall); end
    cyc(); idle_inputs(); #1;
    checks++; if (wen !== 1'b1 || a3 !== 5'd4 || wd !== 32'h44) begin
      errors++; $display("FAIL rstmid_alu: wen=%b a3=%0d wd=%h want 1/4/44", wen, a3, wd);
    end
    repeat (5) cyc();
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rstmid_queue: %0d writes missing, want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_starvation();
    test_x0();
    test_set_wins();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
